// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit width, FSM state encoding and the minimum-digit helper used by
// the elaboration-time parameter check.
package bin2bcd_seq_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  // Number of decimal digits needed to print 2^bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_val;
    int              n;
    max_val = (64'd1 << bin_w) - 64'd1;
    n       = 0;
    while (max_val != 64'd0) begin
      max_val = max_val / 64'd10;
      n       = n + 1;
    end
    if (n == 0) begin
      n = 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle of the binary-to-BCD converter.
// master = requester (drives start/bin), slave = converter.
interface bin2bcd_seq_if
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                      start;
  logic [BIN_W-1:0]          bin;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin2bcd_seq_add3_ge5.sv
// Double-dabble digit correction cell: adds 3 to a BCD digit that is 5 or
// more so that the following left shift carries correctly into the next
// decimal digit. Purely combinational.
module add3_ge5
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  // Correct one digit; codes 13..15 cannot occur in a legal shift register.
  always_comb begin
    d_o = d_i;
    case (d_i)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: d_o = d_i;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
      4'd10, 4'd11, 4'd12:          d_o = d_i + 4'd3;
      default:                      d_o = d_i;
    endcase
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One input bit is
// consumed per clock; a BIN_W-bit word completes BIN_W cycles after the
// request is accepted. The last result is held on bcd until the next one.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
)(
  input  logic          iCLK,
  input  logic          iRST_N,
  bin2bcd_seq_if.slave  bus
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Reject parameter pairs whose digit count cannot hold 2^BIN_W-1.
  generate
    if (BIN_W < 4 || DIGITS < min_digits(BIN_W)) begin : g_param_err
      $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]       corr_s;
  logic [BCD_W+BIN_W-1:0] shift_s;

  // One correction cell per BCD digit of the shift register.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
      add3_ge5 u_add3 (
        .d_i (bcd_sr_q[g*DIGIT_W +: DIGIT_W]),
        .d_o (corr_s[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // Corrected digits and remaining binary bits move left together.
  assign shift_s = {corr_s, bin_sr_q} << 1;

  // Next-state logic: accept a request in IDLE, shift once per cycle in CONV.
  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    bcd_sr_d = bcd_sr_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_CONV;
          bin_sr_d = bus.bin;
          bcd_sr_d = {BCD_W{1'b0}};
          cnt_d    = CNT_W'(BIN_W);
          busy_d   = 1'b1;
        end else begin
          busy_d   = 1'b0;
        end
      end
      ST_CONV: begin
        bcd_sr_d = shift_s[BCD_W+BIN_W-1:BIN_W];
        bin_sr_d = shift_s[BIN_W-1:0];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          bcd_d   = shift_s[BCD_W+BIN_W-1:BIN_W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset wins over all.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q  <= ST_IDLE;
      bin_sr_q <= {BIN_W{1'b0}};
      bcd_sr_q <= {BCD_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= {BCD_W{1'b0}};
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      bcd_sr_q <= bcd_sr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 16-bit/5-digit instance driven by a
// vector table, random values and hand-written handshake sequences, and an
// 8-bit/3-digit instance swept over its whole input range.
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if16 ();
  bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if8  ();

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (.iCLK(clk), .iRST_N(rst_n), .bus(if16));
  bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut8  (.iCLK(clk), .iRST_N(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  // Decimal digits of v, one per nibble, least significant first.
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int ndig);
    logic [31:0] r;
    int unsigned x;
    r = 32'd0;
    x = v;
    for (int i = 0; i < ndig; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request to the 16-bit unit and wait (bounded) for oDone.
  task automatic conv16(input logic [15:0] v, output logic [19:0] res, output int lat);
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = v;
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (if16.done) begin
        lat = c;
        break;
      end
    end
    res = if16.bcd;
  endtask

  task automatic conv8(input logic [7:0] v, output logic [11:0] res, output int lat);
    @(negedge clk);
    if8.start = 1'b1;
    if8.bin   = v;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (if8.done) begin
        lat = c;
        break;
      end
    end
    res = if8.bcd;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [19:0] res;
    logic [11:0] res8;
    int          lat;
    int          ndone;
    int          first_c;
    int          done_c[2];
    logic [19:0] done_v[2];
    logic [15:0] rv;

    vecs[0] = '{16'd0,     20'h00000};
    vecs[1] = '{16'd65535, 20'h65535};
    vecs[2] = '{16'd255,   20'h00255};
    vecs[3] = '{16'd9999,  20'h09999};
    vecs[4] = '{16'd1,     20'h00001};
    vecs[5] = '{16'd10000, 20'h10000};

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    if16.start = 1'b0;
    if16.bin   = 16'd0;
    if8.start  = 1'b0;
    if8.bin    = 8'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(if16.busy), 32'd0);
    check("reset_done", 32'(if16.done), 32'd0);
    check("reset_bcd",  32'(if16.bcd),  32'd0);
    check("reset_bcd8", 32'(if8.bcd),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 6; i++) begin
      conv16(vecs[i].bin, res, lat);
      check("vec_latency", 32'(lat), 32'd16);
      check("vec_result",  32'(res), 32'(vecs[i].exp));
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(if16.done), 32'd0);
      check("idle_busy",      32'(if16.busy), 32'd0);
    end

    // Randomized values against the decimal reference model.
    for (int i = 0; i < 30; i++) begin
      rv = 16'($urandom_range(0, 65535));
      conv16(rv, res, lat);
      check("rand_latency", 32'(lat), 32'd16);
      check("rand_result",  32'(res), ref_bcd(32'(rv), 5));
    end

    // Request while busy is ignored; exactly one completion.
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = 16'd1234;
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    check("busy_after_start", 32'(if16.busy), 32'd1);
    ndone   = 0;
    first_c = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        if16.start = 1'b1;
        if16.bin   = 16'd4321;
      end
      if (c == 6) begin
        if16.start = 1'b0;
      end
      if (if16.done) begin
        ndone++;
        if (first_c == 0) first_c = c;
      end
    end
    check("ignored_ndone",   32'(ndone),    32'd1);
    check("ignored_latency", 32'(first_c),  32'd16);
    check("ignored_result",  32'(if16.bcd), 32'h01234);

    // Result register is not cleared when a new conversion starts.
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = 16'd7;
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    check("hold_at_start", 32'(if16.bcd), 32'h01234);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (if16.done) break;
    end
    check("hold_next_result", 32'(if16.bcd), 32'h00007);

    // Back-to-back: start held high; the second request is taken in the
    // idle cycle in which oDone is high.
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = 16'd42;
    @(posedge clk);
    #1;
    if16.bin = 16'd100;
    ndone = 0;
    done_c[0] = 0; done_c[1] = 0;
    done_v[0] = 20'd0; done_v[1] = 20'd0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (if16.done) begin
        done_c[ndone] = c;
        done_v[ndone] = if16.bcd;
        ndone++;
        if (ndone == 2) break;
      end
    end
    if16.start = 1'b0;
    check("b2b_ndone",  32'(ndone),     32'd2);
    check("b2b_cyc0",   32'(done_c[0]), 32'd16);
    check("b2b_res0",   32'(done_v[0]), 32'h00042);
    check("b2b_cyc1",   32'(done_c[1]), 32'd33);
    check("b2b_res1",   32'(done_v[1]), 32'h00100);

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    if16.start = 1'b1;
    if16.bin   = 16'd500;
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(if16.busy), 32'd0);
    check("abort_done", 32'(if16.done), 32'd0);
    check("abort_bcd",  32'(if16.bcd),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (if16.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    conv16(16'd77, res, lat);
    check("after_abort_latency", 32'(lat), 32'd16);
    check("after_abort_result",  32'(res), 32'h00077);

    // Full sweep of the 8-bit/3-digit instance.
    for (int v = 0; v < 256; v++) begin
      conv8(8'(v), res8, lat);
      check("sweep8_latency", 32'(lat),  32'd8);
      check("sweep8_result",  32'(res8), ref_bcd(32'(v), 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
